// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
//   Definitions shared by the memory access unit, the control unit and the
//   hazard logic:
//     - OP_LD / OP_ST : opcodes whose MemRead/MemWrite decode drives this unit
//     - TIMER_W       : width of the saturating REQ-state timer
//     - mau_state_e   : FSM state encodings (IDLE, REQ, DONE)
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

  localparam logic [3:0] OP_LD = 4'b0111;
  localparam logic [3:0] OP_ST = 4'b1000;

  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_REQ  = 2'd1,
    MAU_DONE = 2'd2
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
//   Data-memory req/ack bus.
//     mem_req   : request, held high until ack or timeout
//     mem_we    : 1 = store, 0 = load
//     mem_addr  : word address
//     mem_wdata : store data
//     mem_ack   : completion from memory (read data valid in the same cycle)
//     mem_rdata : load data
//   master = the memory access unit, slave = the data memory.
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_timeout_ctr.sv
// ---------------------------------------------------------------------------
// mem_access_unit_timeout_ctr
//   Saturating clear/enable counter that times a single bus request.
//   Ports:
//     clk    : clock, rising edge
//     rst    : synchronous reset, active-high
//     clr_i  : clear to zero (has priority over enable)
//     en_i   : count up by one, saturating at all-ones
//     tc_o   : terminal count, high while count == TIMEOUT-1
// ---------------------------------------------------------------------------
module mem_access_unit_timeout_ctr
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TIMER_W-1:0] TC_VAL = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage engine: turns a MemRead/MemWrite request from EX/MEM into one
//   req/ack transaction on the data-memory bus, stalls the pipeline until it
//   completes (or times out) and hands load data to writeback.
//   Ports:
//     clk, rst        : clock / synchronous active-high reset
//     MemRead/MemWrite: load / store request (both high = store + err)
//     addr, wdata     : effective address and store data
//     stall           : hold PC and pipeline registers
//     rdata           : load result (0 after a timeout)
//     rdata_valid     : one-cycle completion pulse
//     err             : one-cycle pulse on timeout or illegal request
//     mem             : data-memory bus (master side)
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err,
  mem_access_unit_if.master mem
);

  mau_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic go;
  logic tmr_clr, tmr_en, tmr_tc;

  assign go = MemRead | MemWrite;

  mem_access_unit_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    stall       = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      MAU_IDLE: begin
        // Stall combinationally so the requesting instruction is held in EX/MEM.
        stall = go;
        if (go) begin
          mem_addr_d  = addr;
          mem_wdata_d = wdata;
          mem_we_d    = MemWrite;          // read+write together resolves to a store
          err_d       = MemRead & MemWrite; // flagged in the first REQ cycle
          tmr_clr     = 1'b1;
          state_d     = MAU_REQ;
        end
      end
      MAU_REQ: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          if (!mem_we_q) begin
            rdata_d = mem.mem_rdata;
          end
          state_d = MAU_DONE;
        end else if (tmr_tc) begin
          // Abort: no ack within TIMEOUT cycles; error shows in the DONE cycle.
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = MAU_DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      MAU_DONE: begin
        // Pipeline advances on this edge; a go seen here is the old instruction.
        state_d = MAU_IDLE;
      end
      default: begin
        state_d = MAU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MAU_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_req   = (state_q == MAU_REQ);
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign rdata         = rdata_q;
  assign rdata_valid   = (state_q == MAU_DONE);
  assign err           = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Drives load/store/illegal requests with a responding memory that acks
//   after a chosen number of wait cycles (or never), and compares the whole
//   transaction against a transaction-level model: stall length, request
//   length, error pulses, bus stability and the returned data.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              MemRead, MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              stall, rdata_valid, err;
  logic [DATA_W-1:0] rdata;

  mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  mem_access_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .err         (err),
    .mem         (mif.master)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int n_op   = 0;

  // Last value writeback should see on rdata.
  logic [DATA_W-1:0] model_rdata = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {stall, rdata, rdata_valid, err, mif.mem_req, mif.mem_we,
            mif.mem_addr, mif.mem_wdata};
  endfunction

  // One memory operation starting in IDLE at posedge+1. The memory acks in
  // REQ cycle number 'w' (0-based); w >= TIMEOUT means it never acks.
  task automatic run_op(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input int w,
                        input logic [DATA_W-1:0] rv);
    bit                timeout = (w >= TIMEOUT);
    int                exp_req = timeout ? TIMEOUT : w + 1;
    logic [DATA_W-1:0] exp_rdata;
    int stall_cnt = 0, req_cnt = 0, err_req = 0, err_done = 0, unstable = 0, cycles = 0;
    bit done = 0;

    if (timeout)  exp_rdata = '0;
    else if (wr)  exp_rdata = model_rdata;
    else          exp_rdata = rv;

    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = d;

    while (!done && cycles < 60) begin
      mif.mem_ack   = mif.mem_req && (req_cnt == w);
      mif.mem_rdata = mif.mem_ack ? rv : DATA_W'($urandom);
      @(negedge clk);
      if (stall) stall_cnt++;
      if (mif.mem_req) begin
        if (mif.mem_addr !== a || mif.mem_wdata !== d || mif.mem_we !== wr) unstable++;
        if (err) err_req++;
        req_cnt++;
      end
      if (rdata_valid) begin
        done = 1;
        if (err) err_done++;
        check_eq("done_stall", stall, 0);
        check_eq("done_mem_req", mif.mem_req, 0);
        check_eq("rdata", rdata, exp_rdata);
      end
      @(posedge clk);
      #1;
      mif.mem_ack = 1'b0;
      cycles++;
    end

    // Pipeline advances on the DONE edge: the request is withdrawn.
    MemRead  = 1'b0;
    MemWrite = 1'b0;

    check_eq("completed", done, 1);
    check_eq("stall_cycles", stall_cnt, 1 + exp_req);
    check_eq("req_cycles", req_cnt, exp_req);
    check_eq("err_in_req", err_req, (rd && wr) ? 1 : 0);
    check_eq("err_in_done", err_done, timeout ? 1 : 0);
    check_eq("bus_stable", unstable, 0);

    $display("op %0d: %s addr=0x%04h wdata=0x%04h wait=%0d -> stall=%0d req=%0d rdata=0x%04h%s",
             n_op, (rd && wr) ? "ILL" : (wr ? "ST " : "LD "), a, d, w, stall_cnt, req_cnt,
             rdata, timeout ? " timeout" : "");
    n_op++;
    model_rdata = exp_rdata;
  endtask

  // Idle cycles with a possible stray ack that must be ignored.
  task automatic idle_gap(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      mif.mem_ack   = stray;
      mif.mem_rdata = DATA_W'($urandom);
      @(negedge clk);
      check_eq("idle_rdata_valid", rdata_valid, 0);
      check_eq("idle_stall", stall, 0);
      check_eq("idle_mem_req", mif.mem_req, 0);
      check_eq("idle_rdata", rdata, model_rdata);
      @(posedge clk);
      #1;
      mif.mem_ack = 1'b0;
    end
  endtask

  initial begin
    rst           = 1'b1;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    addr          = '0;
    wdata         = '0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("reset_outputs", all_outputs(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed: load with immediate ack, store with 3 waits, timeout, illegal.
    run_op(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF);
    idle_gap(1, 1'b0);
    run_op(1'b0, 1'b1, 16'h0010, 16'h1234, 3, 16'h5555);
    idle_gap(1, 1'b0);
    run_op(1'b1, 1'b0, 16'h0020, 16'h0000, 100, 16'h7777);
    idle_gap(1, 1'b0);
    run_op(1'b1, 1'b0, 16'h0030, 16'h0000, 1, 16'h4321);
    run_op(1'b1, 1'b1, 16'h0044, 16'hA5A5, 1, 16'h9999);
    idle_gap(1, 1'b0);

    // Reset in REQ wait cycle 2, then a late ack that must be ignored.
    MemRead = 1'b1;
    addr    = 16'h0040;
    wdata   = 16'h0BAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst      = 1'b1;
    MemRead  = 1'b0;
    @(posedge clk); #1;
    rst           = 1'b0;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 16'hDEAD;
    @(negedge clk);
    check_eq("midreq_reset_outputs", all_outputs(), 0);
    @(posedge clk); #1;
    mif.mem_ack = 1'b0;
    @(negedge clk);
    check_eq("late_ack_ignored", {rdata_valid, rdata, stall, mif.mem_req}, 0);
    @(posedge clk); #1;
    model_rdata = '0;
    $display("op %0d: reset during REQ wait cycle 2, late ack ignored", n_op);
    n_op++;

    // Back-to-back LD then ST, then a stray ack in IDLE.
    run_op(1'b1, 1'b0, 16'h0100, 16'h0000, 0, 16'hCAFE);
    run_op(1'b0, 1'b1, 16'h0102, 16'hF00D, 0, 16'h1111);
    idle_gap(2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int  kind = $urandom_range(0, 9);
      bit  rd   = (kind < 5) || (kind == 9);
      bit  wr   = (kind >= 5);
      int  w    = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 4)
                                              : $urandom_range(0, TIMEOUT - 1);
      run_op(rd, wr, ADDR_W'($urandom), DATA_W'($urandom), w, DATA_W'($urandom));
      idle_gap($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
